nibble_serial_addsub: RTL
=========================

# nibble_serial_addsub

Sequential byte adder/subtractor that processes two 8-bit operands one nibble at a time, low nibble first, carrying or borrowing between nibble steps through an internal register. It is the multi-cycle, bidirectional (add and subtract) counterpart of the team's combinational nibble adder. It sits behind a simple start/done handshake so a controller can issue byte operations and collect a registered result plus carry/borrow flag.

## Interface

- No parameters; operand width fixed at 8 bits (two 4-bit nibbles).
- clk    in   1  system clock; all state updates on rising edge.
- rst    in   1  reset, asynchronous, active-high.
- start  in   1  request; sampled on rising clk when busy=0.
- op     in   1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
- A      in   8  operand A; sampled with start.
- B      in   8  operand B; sampled with start.
- busy   out  1  high while a nibble step is in progress.
- done   out  1  one-cycle pulse: result/cb valid.
- result out  8  registered 8-bit sum/difference.
- cb     out  1  add: carry out of bit 7; subtract: borrow (1 when A<B unsigned).

## Operation

- States: IDLE, LO, HI, DONE. Reset state IDLE.
- IDLE/DONE with start=1: latch A, B, op into internal registers, clear internal carry/borrow, go to LO. With start=0: DONE→IDLE, IDLE stays.
- LO: low nibble step → partial[3:0] and internal carry/borrow; go to HI.
  - add: {c, partial[3:0]} = A[3:0] + B[3:0].
  - sub: {bw, partial[3:0]} = A[3:0] - B[3:0], with bw=1 when A[3:0] < B[3:0].
- HI: high nibble step including the internal carry/borrow from LO. Load result[7:0] = {high nibble, partial[3:0]} and cb = final carry/borrow. Go to DONE.
  - add: high nibble = A[7:4] + B[7:4] + c; cb = carry out.
  - sub: high nibble = A[7:4] - B[7:4] - bw; cb = final borrow.
- Arithmetic is unsigned, modulo 256. cb is the only overflow indication.
- result and cb change only on the HI→DONE edge. They hold their value through later operations until the next HI→DONE edge.
- start while busy=1 is ignored. Latched operands and op are unaffected by A/B/op changes during LO/HI.
- rst asserted at any time, including mid-operation: immediately go to IDLE and clear all registers. Any in-flight operation is abandoned with no done pulse.

## Timing

- Reset values: busy=0, done=0, result=8'h00, cb=0; internal operand and partial registers are 0.
- busy is 1 exactly in LO and HI. done is 1 exactly in DONE.
- Latency: start sampled at edge N → busy high after N → result, cb and done valid after edge N+2 → done low after N+3, unless a new start is sampled at N+3.
- Back-to-back: start held high in DONE is accepted at edge N+3. Throughput is one operation per 3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Add 8'hCA + 8'hAD, op=0 → done 3 edges after start, result=8'h77, cb=1. busy is high for exactly 2 cycles.
- Add 8'hFF + 8'h80 → result=8'h7F, cb=1. Add 8'h0F + 8'h01 → result=8'h10, cb=0, checking nibble carry propagation.
- Subtract 8'h00 - 8'hAA → result=8'h56, cb=1. Subtract 8'hD5 - 8'hAA → result=8'h2B, cb=0. Subtract 8'h10 - 8'h01 → result=8'h0F, cb=0, checking nibble borrow propagation.
- Subtract 8'hFF - 8'hFF → result=8'h00, cb=0. Then hold start=1 continuously with A=8'h01, B=8'h02, op=0 → operations accepted every 3 cycles, each giving result=8'h03, cb=0.
- During an active add (8'h12+8'h34), pulse start with new A/B and also change A/B/op → request ignored, result=8'h46, cb=0, and only one done pulse.
- Assert rst in state HI of 8'hCA+8'hAD, after a prior result of 8'h77 → outputs go to 0 immediately (asynchronously) and no done pulse follows. The next operation 8'h01-8'h02 gives result=8'hFF, cb=1.

Source files
------------

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
// Sequential 8-bit adder/subtractor that works one nibble per clock, low
// nibble first. A carry or borrow passes between the two nibble steps
// through an internal register. Operations are issued with a start/done
// handshake.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : operation request, accepted only when not busy (IDLE or DONE)
//   op     : 0 = A + B, 1 = A - B (sampled with start)
//   A, B   : 8-bit unsigned operands (sampled with start)
//   busy   : high while a nibble step is in progress (states LO and HI)
//   done   : one-cycle pulse; result and cb have just been updated
//   result : registered 8-bit sum or difference, modulo 256
//   cb     : add -> carry out of bit 7, subtract -> borrow (A < B)
module nibble_serial_addsub (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       cb
);

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned NIB_EXT_W = NIB_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [BYTE_W-1:0] a_q;
    logic [BYTE_W-1:0] b_q;
    logic              op_q;
    logic              cb_int;
    logic [NIB_W-1:0]  partial;

    logic                 accept_c;
    logic [NIB_W-1:0]     nib_a_c;
    logic [NIB_W-1:0]     nib_b_c;
    logic                 nib_cin_c;
    logic [NIB_EXT_W-1:0] nib_res_c;

    // A request is taken only when no nibble step is running.
    assign accept_c = start && ((state == IDLE) || (state == DONE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = LO;
            end
            LO: begin
                state_next = HI;
            end
            HI: begin
                state_next = DONE;
            end
            DONE: begin
                if (start) state_next = LO;
                else       state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy/done come from flops loaded with the decode of the next state,
    // so they line up exactly with LO/HI and DONE without a comb output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == LO) || (state_next == HI);
            done <= (state_next == DONE);
        end
    end

    // Shared nibble ALU: selects the low or high nibble depending on the step.
    // Bit NIB_W of the 5-bit result is the carry (add) or the borrow (sub),
    // because a negative difference wraps and sets that bit.
    always_comb begin
        nib_a_c   = a_q[NIB_W-1:0];
        nib_b_c   = b_q[NIB_W-1:0];
        nib_cin_c = 1'b0;
        nib_res_c = '0;
        if (state == HI) begin
            nib_a_c   = a_q[BYTE_W-1:NIB_W];
            nib_b_c   = b_q[BYTE_W-1:NIB_W];
            nib_cin_c = cb_int;
        end
        if (op_q) begin
            nib_res_c = NIB_EXT_W'(nib_a_c) - NIB_EXT_W'(nib_b_c) - NIB_EXT_W'(nib_cin_c);
        end else begin
            nib_res_c = NIB_EXT_W'(nib_a_c) + NIB_EXT_W'(nib_b_c) + NIB_EXT_W'(nib_cin_c);
        end
    end

    // Operand capture and the inter-nibble carry/borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            cb_int  <= 1'b0;
            partial <= '0;
        end else begin
            if (accept_c) begin
                a_q    <= A;
                b_q    <= B;
                op_q   <= op;
                cb_int <= 1'b0;
            end else if (state == LO) begin
                partial <= nib_res_c[NIB_W-1:0];
                cb_int  <= nib_res_c[NIB_W];
            end
        end
    end

    // Result is only written on the HI step and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            cb     <= 1'b0;
        end else if (state == HI) begin
            result <= {nib_res_c[NIB_W-1:0], partial};
            cb     <= nib_res_c[NIB_W];
        end
    end

endmodule
